mem_access_stage: RTL and testbench

//  MEM stage of the 5-stage pipeline: sits between the EX/MEM register and the MEM/WB register.

---
 rtl/mem_access_stage.sv | 202 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage pipeline.
// Converts EX/MEM load/store control into a req/ack data-memory transaction,
// formats load data for MEM/WB and stalls the front of the pipeline while an
// access is outstanding.
// Optional build macro: MEM_MISALIGN_TRAP_EN
//   Defined: misaligned half/word accesses are not issued, and misalign_err pulses.
//   Undefined: misalign_err does not exist, and the unused low address bits are ignored.
// Only DATA_W = 32 (four byte lanes) is supported.

module mem_access_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_CPU,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [1:0]        mem_size_in,
    input  logic              mem_unsigned_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] mem_rd_out,
    output logic              mem_stall
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state, state_next;

    logic              access;
    logic              issue;
    logic              complete;
    logic [3:0]        be_calc;
    logic [DATA_W-1:0] wdata_calc;
    logic [DATA_W-1:0] load_fmt;

    // Access attributes captured at issue so the load formatting does not
    // depend on addr_in, which may change once the pipeline moves on.
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic              unsigned_q;

    assign access = mem_read_in | mem_write_in;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    logic trap;
    assign misaligned = ((mem_size_in == 2'b01) & addr_in[0]) |
                        (mem_size_in[1] & (addr_in[1:0] != 2'b00));
`endif

    // Byte enables and lane-replicated store data for the current request
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = wdata_in;
        case (mem_size_in)
            2'b00: begin
                be_calc    = 4'b0001 << addr_in[1:0];
                wdata_calc = {4{wdata_in[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << {addr_in[1], 1'b0};
                wdata_calc = {2{wdata_in[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = wdata_in;
            end
        endcase
    end

    // Lane select and sign/zero extension of the raw read word
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = dmem_rdata[7:0];
        case (lane_q)
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            2'b00:   load_fmt = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_fmt = {{16{~unsigned_q & half_sel[15]}}, half_sel};
            default: load_fmt = dmem_rdata;
        endcase
    end

    // Next state, issue/complete strobes and pipeline stall
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        complete   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (enable_CPU && access) begin
`ifdef MEM_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        trap       = 1'b1;
                        state_next = DONE;
                    end else begin
                        issue      = 1'b1;
                        state_next = BUSY;
                    end
`else
                    issue      = 1'b1;
                    state_next = BUSY;
`endif
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    complete   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (enable_CPU) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        mem_stall = ((state == IDLE) && enable_CPU && access) || (state == BUSY);
    end

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus request registers, held stable from issue until ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= '0;
            lane_q     <= 2'b00;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
        end else if (issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_in;
            dmem_addr  <= {addr_in[ADDR_W-1:2], 2'b00};
            dmem_be    <= mem_write_in ? be_calc : 4'b1111;
            dmem_wdata <= wdata_calc;
            lane_q     <= addr_in[1:0];
            size_q     <= mem_size_in;
            unsigned_q <= mem_unsigned_in;
        end else if (complete) begin
            dmem_req   <= 1'b0;
        end
    end

    // Load result register; stores leave the last load value in place
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_out <= '0;
        end else if (complete && !dmem_we) begin
            mem_rd_out <= load_fmt;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // One-cycle error pulse for a rejected misaligned access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= trap;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: self-checking bench for mem_access_stage.
// Table-driven load/store vectors with a queue scoreboard of expected load
// results, plus hand-written sequences for reset, DONE hold and ack-in-IDLE.
// Build with MEM_MISALIGN_TRAP_EN defined to exercise the misalignment trap.

module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_CPU;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [1:0]  mem_size_in;
    logic        mem_unsigned_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] mem_rd_out;
    logic        mem_stall;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expRd;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] scoreboard[$];
    int          vectorsApplied = 0;
    int          miscompares = 0;
    int          reqRises = 0;
    int          risesBefore;

    mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_CPU      (enable_CPU),
        .mem_read_in     (mem_read_in),
        .mem_write_in    (mem_write_in),
        .mem_size_in     (mem_size_in),
        .mem_unsigned_in (mem_unsigned_in),
        .addr_in         (addr_in),
        .wdata_in        (wdata_in),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_be         (dmem_be),
        .dmem_wdata      (dmem_wdata),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata),
        .mem_rd_out      (mem_rd_out),
        .mem_stall       (mem_stall)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_err    (misalign_err)
`endif
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Counts request pulses so re-issues can be detected
    always @(posedge dmem_req) begin
        reqRises <= reqRises + 1;
    end

    // Hard stop in case the bench itself gets stuck
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mkVec(input logic rd, input logic wr, input logic [1:0] size,
                                   input logic uns, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata,
                                   input int delay, input logic [31:0] expAddr,
                                   input logic [3:0] expBe, input logic [31:0] expWdata,
                                   input logic [31:0] expRd);
        vec_t v;
        v.rd = rd;       v.wr = wr;         v.size = size;        v.uns = uns;
        v.addr = addr;   v.wdata = wdata;   v.rdata = rdata;      v.delay = delay;
        v.expAddr = expAddr; v.expBe = expBe; v.expWdata = expWdata; v.expRd = expRd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        mem_read_in     = 1'b0;
        mem_write_in    = 1'b0;
        mem_size_in     = 2'b00;
        mem_unsigned_in = 1'b0;
        addr_in         = 32'h0;
        wdata_in        = 32'h0;
    endtask

    // Drives one access, plays the memory with the vector's ack delay and
    // compares the bus fields and the formatted load result
    task automatic applyStimulus(input vec_t v);
        int          waited;
        logic [31:0] expRd;
        @(negedge clk);
        enable_CPU      = 1'b1;
        mem_read_in     = v.rd;
        mem_write_in    = v.wr;
        mem_size_in     = v.size;
        mem_unsigned_in = v.uns;
        addr_in         = v.addr;
        wdata_in        = v.wdata;
        scoreboard.push_back(v.expRd);
        #1;
        checkOutput("stall_issue", {31'b0, mem_stall}, 32'd1);
        @(negedge clk);
        waited = 0;
        while (!dmem_req && waited < 4) begin
            waited++;
            @(negedge clk);
        end
        if (!dmem_req) begin
            checkOutput("req_timeout", {31'b0, dmem_req}, 32'd1);
            expRd = scoreboard.pop_front();
            clearInputs();
            return;
        end
        checkOutput("dmem_addr", dmem_addr, v.expAddr);
        checkOutput("dmem_be", {28'b0, dmem_be}, {28'b0, v.expBe});
        checkOutput("dmem_we", {31'b0, dmem_we}, {31'b0, v.wr});
        if (v.wr) begin
            checkOutput("dmem_wdata", dmem_wdata, v.expWdata);
        end
        for (int k = 1; k <= v.delay; k++) begin
            checkOutput("req_held", {31'b0, dmem_req}, 32'd1);
            checkOutput("stall_busy", {31'b0, mem_stall}, 32'd1);
            if (k == v.delay) begin
                dmem_ack   = 1'b1;
                dmem_rdata = v.rdata;
            end else begin
                dmem_rdata = ~v.rdata;
            end
            @(negedge clk);
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        checkOutput("req_drop", {31'b0, dmem_req}, 32'd0);
        checkOutput("stall_done", {31'b0, mem_stall}, 32'd0);
        expRd = scoreboard.pop_front();
        checkOutput("mem_rd_out", mem_rd_out, expRd);
        clearInputs();
        @(negedge clk);
        checkOutput("req_idle", {31'b0, dmem_req}, 32'd0);
    endtask

    initial begin
        // Vector table: rd, wr, size, uns, addr, wdata, rdata, delay, expAddr, expBe, expWdata, expRd
        vecs.push_back(mkVec(1, 0, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 3, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF));
        vecs.push_back(mkVec(1, 0, 2'b00, 0, 32'h103, 32'h0,        32'h80FF1234, 1, 32'h100, 4'b1111, 32'h0,        32'hFFFFFF80));
        vecs.push_back(mkVec(1, 0, 2'b00, 1, 32'h103, 32'h0,        32'h80FF1234, 2, 32'h100, 4'b1111, 32'h0,        32'h00000080));
        vecs.push_back(mkVec(0, 1, 2'b01, 0, 32'h102, 32'h0000ABCD, 32'h0,        1, 32'h100, 4'b1100, 32'hABCDABCD, 32'h00000080));
        vecs.push_back(mkVec(0, 1, 2'b00, 0, 32'h201, 32'h123456A5, 32'h0,        2, 32'h200, 4'b0010, 32'hA5A5A5A5, 32'h00000080));
        vecs.push_back(mkVec(1, 0, 2'b01, 0, 32'h106, 32'h0,        32'h9ABC1234, 1, 32'h104, 4'b1111, 32'h0,        32'hFFFF9ABC));
        vecs.push_back(mkVec(1, 0, 2'b01, 1, 32'h104, 32'h0,        32'h9ABC8765, 1, 32'h104, 4'b1111, 32'h0,        32'h00008765));
        vecs.push_back(mkVec(1, 0, 2'b00, 0, 32'h101, 32'h0,        32'h11227F33, 1, 32'h100, 4'b1111, 32'h0,        32'h0000007F));
        vecs.push_back(mkVec(0, 1, 2'b10, 0, 32'h300, 32'hCAFEF00D, 32'h0,        1, 32'h300, 4'b1111, 32'hCAFEF00D, 32'h0000007F));
        vecs.push_back(mkVec(1, 0, 2'b11, 0, 32'h10C, 32'h0,        32'h01234567, 1, 32'h10C, 4'b1111, 32'h0,        32'h01234567));
        vecs.push_back(mkVec(1, 1, 2'b10, 0, 32'h400, 32'h13579BDF, 32'h0,        1, 32'h400, 4'b1111, 32'h13579BDF, 32'h01234567));
        vecs.push_back(mkVec(1, 0, 2'b00, 0, 32'h10A, 32'h0,        32'h00C30000, 1, 32'h108, 4'b1111, 32'h0,        32'hFFFFFFC3));
        vecs.push_back(mkVec(0, 1, 2'b00, 0, 32'h00B, 32'h0000005A, 32'h0,        1, 32'h008, 4'b1000, 32'h5A5A5A5A, 32'hFFFFFFC3));
`ifndef MEM_MISALIGN_TRAP_EN
        vecs.push_back(mkVec(1, 0, 2'b01, 1, 32'h101, 32'h0,        32'hAAAA5555, 1, 32'h100, 4'b1111, 32'h0,        32'h00005555));
        vecs.push_back(mkVec(0, 1, 2'b10, 0, 32'h102, 32'h11223344, 32'h0,        1, 32'h100, 4'b1111, 32'h11223344, 32'h00005555));
`endif

        // Reset state
        rst_n      = 1'b0;
        enable_CPU = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        clearInputs();
        #12;
        checkOutput("rst_req", {31'b0, dmem_req}, 32'd0);
        checkOutput("rst_we", {31'b0, dmem_we}, 32'd0);
        checkOutput("rst_addr", dmem_addr, 32'h0);
        checkOutput("rst_be", {28'b0, dmem_be}, 32'h0);
        checkOutput("rst_wdata", dmem_wdata, 32'h0);
        checkOutput("rst_rd_out", mem_rd_out, 32'h0);
        checkOutput("rst_stall", {31'b0, mem_stall}, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        checkOutput("rst_misalign", {31'b0, misalign_err}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Ack while idle must be ignored
        @(negedge clk);
        enable_CPU = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        checkOutput("idle_ack_req", {31'b0, dmem_req}, 32'd0);
        checkOutput("idle_ack_rd", mem_rd_out, 32'h0);
        checkOutput("idle_ack_stall", {31'b0, mem_stall}, 32'd0);

        // Table-driven vectors
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end

        // enable_CPU held low in DONE: one request only, then back to IDLE
        risesBefore = reqRises;
        @(negedge clk);
        enable_CPU   = 1'b1;
        mem_read_in  = 1'b1;
        mem_size_in  = 2'b10;
        addr_in      = 32'h500;
        @(negedge clk);
        checkOutput("hold_req", {31'b0, dmem_req}, 32'd1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h55AA00FF;
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        enable_CPU = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checkOutput("hold_no_req", {31'b0, dmem_req}, 32'd0);
            checkOutput("hold_no_stall", {31'b0, mem_stall}, 32'd0);
            @(negedge clk);
        end
        enable_CPU = 1'b1;
        clearInputs();
        @(negedge clk);
        checkOutput("hold_idle_req", {31'b0, dmem_req}, 32'd0);
        checkOutput("hold_rd_out", mem_rd_out, 32'h55AA00FF);
        checkOutput("hold_pulses", reqRises - risesBefore, 32'd1);

        // Reset asserted while BUSY
        @(negedge clk);
        mem_read_in = 1'b1;
        mem_size_in = 2'b10;
        addr_in     = 32'h600;
        @(negedge clk);
        checkOutput("abort_req_before", {31'b0, dmem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_req", {31'b0, dmem_req}, 32'd0);
        checkOutput("abort_addr", dmem_addr, 32'h0);
        checkOutput("abort_be", {28'b0, dmem_be}, 32'h0);
        checkOutput("abort_rd_out", mem_rd_out, 32'h0);
        clearInputs();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mkVec(1, 0, 2'b10, 0, 32'h700, 32'h0, 32'h0BADF00D, 2, 32'h700, 4'b1111, 32'h0, 32'h0BADF00D));

`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned word load is trapped rather than issued
        risesBefore = reqRises;
        @(negedge clk);
        mem_read_in = 1'b1;
        mem_size_in = 2'b10;
        addr_in     = 32'h102;
        #1;
        checkOutput("trap_stall0", {31'b0, mem_stall}, 32'd1);
        @(negedge clk);
        checkOutput("trap_err", {31'b0, misalign_err}, 32'd1);
        checkOutput("trap_req", {31'b0, dmem_req}, 32'd0);
        checkOutput("trap_stall1", {31'b0, mem_stall}, 32'd0);
        clearInputs();
        @(negedge clk);
        checkOutput("trap_err_clr", {31'b0, misalign_err}, 32'd0);
        checkOutput("trap_rd_out", mem_rd_out, 32'h0BADF00D);
        checkOutput("trap_pulses", reqRises - risesBefore, 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
